// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, FSM states,
// datapath mux selects and the decoded opcode class.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic rtype;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic addi;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/mips_ctrl_opdecode.sv
// Combinational opcode classifier: exactly one class bit is set per opcode.
module mips_ctrl_opdecode
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter bit ENABLE_ADDI = 1
) (
    input  logic [OPCODE_W-1:0] opcode,
    output op_class_t           cls
);

    always_comb begin
        cls         = '0;
        cls.rtype   = (opcode == OPCODE_W'(OP_RTYPE));
        cls.lw      = (opcode == OPCODE_W'(OP_LW));
        cls.sw      = (opcode == OPCODE_W'(OP_SW));
        cls.beq     = (opcode == OPCODE_W'(OP_BEQ));
        cls.j       = (opcode == OPCODE_W'(OP_J));
        cls.addi    = ENABLE_ADDI && (opcode == OPCODE_W'(OP_ADDI));
        cls.illegal = !(cls.rtype || cls.lw || cls.sw || cls.beq || cls.j || cls.addi);
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared memory port stalled by mem_ready.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W        = 6,
    parameter int ALU_OP_W        = 2,
    parameter bit ENABLE_ADDI     = 1,
    parameter bit TRAP_ON_ILLEGAL = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          pc_source,
    output logic [3:0]          state,
    output logic                illegal_op,
    output logic                instr_retired
);

    state_t    state_q, state_d;
    logic      is_sw_q;
    op_class_t cls;
    logic [1:0] aop;

    mips_ctrl_opdecode #(
        .OPCODE_W    (OPCODE_W),
        .ENABLE_ADDI (ENABLE_ADDI)
    ) u_opdecode (
        .opcode (opcode),
        .cls    (cls)
    );

    // lw/sw distinction is captured in DECODE so MEMADR ignores later opcode changes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            is_sw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) is_sw_q <= cls.sw;
        end
    end

    // Outputs are forced low for the whole time rst_n is held, not just at the edge
    always_comb begin
        state_d       = S_FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        aop           = ALU_ADD;
        pc_source     = PCSRC_ALU;
        illegal_op    = 1'b0;
        instr_retired = 1'b0;
        state         = '0;
        if (rst_n) begin
            state = state_q;
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    state_d   = S_FETCH;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_b = SRCB_IMM_SH;
                    if (cls.illegal) begin
                        if (TRAP_ON_ILLEGAL) state_d = S_TRAP;
                        else illegal_op = 1'b1;
                    end
                    else if (cls.lw || cls.sw) state_d = S_MEMADR;
                    else if (cls.rtype)        state_d = S_EXEC;
                    else if (cls.beq)          state_d = S_BRANCH;
                    else if (cls.j)            state_d = S_JUMP;
                    else if (cls.addi)         state_d = S_ADDIEX;
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    state_d   = is_sw_q ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    state_d  = mem_ready ? S_MEMWB : S_MEMRD;
                end
                S_MEMWB: begin
                    reg_write     = 1'b1;
                    mem_to_reg    = 1'b1;
                    instr_retired = 1'b1;
                end
                S_MEMWR: begin
                    mem_write     = 1'b1;
                    i_or_d        = 1'b1;
                    instr_retired = mem_ready;
                    state_d       = mem_ready ? S_FETCH : S_MEMWR;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    aop       = ALU_FUNCT;
                    state_d   = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write     = 1'b1;
                    reg_dst       = 1'b1;
                    instr_retired = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    aop           = ALU_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = PCSRC_ALUOUT;
                    instr_retired = 1'b1;
                end
                S_JUMP: begin
                    pc_write      = 1'b1;
                    pc_source     = PCSRC_JUMP;
                    instr_retired = 1'b1;
                end
                S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    state_d   = S_ADDIWB;
                end
                S_ADDIWB: begin
                    reg_write     = 1'b1;
                    instr_retired = 1'b1;
                end
                S_TRAP: begin
                    illegal_op = 1'b1;
                    state_d    = S_TRAP;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign alu_op = ALU_OP_W'(aop);

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench: two controllers (trap / nop on illegal opcode) share stimulus;
// per-cycle expected output words are queued and checked on the falling edge.
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic       mem_ready = 1'b0;

    logic       pcw1, pcwc1, iord1, mr1, mw1, irw1, m2r1, rd1, rw1, asa1, ill1, ret1;
    logic       pcw0, pcwc0, iord0, mr0, mw0, irw0, m2r0, rd0, rw0, asa0, ill0, ret0;
    logic [1:0] asb1, aop1, psrc1, asb0, aop0, psrc0;
    logic [3:0] st1, st0;
    logic [21:0] o1, o0;

    typedef struct {
        logic [21:0] v;
        string       name;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mips_multicycle_control #(.TRAP_ON_ILLEGAL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pcw1), .pc_write_cond(pcwc1), .i_or_d(iord1), .mem_read(mr1),
        .mem_write(mw1), .ir_write(irw1), .mem_to_reg(m2r1), .reg_dst(rd1),
        .reg_write(rw1), .alu_src_a(asa1), .alu_src_b(asb1), .alu_op(aop1),
        .pc_source(psrc1), .state(st1), .illegal_op(ill1), .instr_retired(ret1)
    );

    mips_multicycle_control #(.TRAP_ON_ILLEGAL(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pcw0), .pc_write_cond(pcwc0), .i_or_d(iord0), .mem_read(mr0),
        .mem_write(mw0), .ir_write(irw0), .mem_to_reg(m2r0), .reg_dst(rd0),
        .reg_write(rw0), .alu_src_a(asa0), .alu_src_b(asb0), .alu_op(aop0),
        .pc_source(psrc0), .state(st0), .illegal_op(ill0), .instr_retired(ret0)
    );

    assign o1 = {pcw1, pcwc1, iord1, mr1, mw1, irw1, m2r1, rd1, rw1, asa1,
                 asb1, aop1, psrc1, st1, ill1, ret1};
    assign o0 = {pcw0, pcwc0, iord0, mr0, mw0, irw0, m2r0, rd0, rw0, asa0,
                 asb0, aop0, psrc0, st0, ill0, ret0};

    // Word layout: pcw pcwc iord mr mw irw m2r rd rw asa | asb aop psrc | state | ill ret
    function automatic logic [21:0] mk(
        input logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa,
        input logic [1:0] asb, aop, psrc,
        input logic [3:0] st,
        input logic ill, ret);
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, st, ill, ret};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            checks++;
            if (o1 !== e.v) begin
                errors++;
                $display("FAIL trap1 %s: got %h expected %h", e.name, o1, e.v);
            end
        end
        if (q0.size() > 0) begin
            e = q0.pop_front();
            checks++;
            if (o0 !== e.v) begin
                errors++;
                $display("FAIL trap0 %s: got %h expected %h", e.name, o0, e.v);
            end
        end
    end

    task automatic step(input logic rst, input logic [5:0] opc, input logic rdy,
                        input logic [21:0] e1, input logic [21:0] e0, input string name);
        @(posedge clk);
        #1;
        rst_n     = rst;
        opcode    = opc;
        mem_ready = rdy;
        q1.push_back('{v: e1, name: name});
        q0.push_back('{v: e0, name: name});
    endtask

    logic [21:0] ZERO, F_WAIT, F_RDY, DEC, DEC_ILL, MA, MR_WAIT, MR_RDY, MWB;
    logic [21:0] MW_WAIT, MW_RDY, EX, AWB, BR, JMP, AX, AXWB, TRP;

    initial begin
        ZERO    = '0;
        //            pcw pcwc iord mr mw irw m2r rd rw asa  asb    aop    psrc   st    ill ret
        F_WAIT  = mk(0,  0,   0,   1, 0, 0,  0,  0, 0, 0,  2'b01, 2'b00, 2'b00, 4'd0,  0, 0);
        F_RDY   = mk(1,  0,   0,   1, 0, 1,  0,  0, 0, 0,  2'b01, 2'b00, 2'b00, 4'd0,  0, 0);
        DEC     = mk(0,  0,   0,   0, 0, 0,  0,  0, 0, 0,  2'b11, 2'b00, 2'b00, 4'd1,  0, 0);
        DEC_ILL = mk(0,  0,   0,   0, 0, 0,  0,  0, 0, 0,  2'b11, 2'b00, 2'b00, 4'd1,  1, 0);
        MA      = mk(0,  0,   0,   0, 0, 0,  0,  0, 0, 1,  2'b10, 2'b00, 2'b00, 4'd2,  0, 0);
        MR_WAIT = mk(0,  0,   1,   1, 0, 0,  0,  0, 0, 0,  2'b00, 2'b00, 2'b00, 4'd3,  0, 0);
        MR_RDY  = MR_WAIT;
        MWB     = mk(0,  0,   0,   0, 0, 0,  1,  0, 1, 0,  2'b00, 2'b00, 2'b00, 4'd4,  0, 1);
        MW_WAIT = mk(0,  0,   1,   0, 1, 0,  0,  0, 0, 0,  2'b00, 2'b00, 2'b00, 4'd5,  0, 0);
        MW_RDY  = mk(0,  0,   1,   0, 1, 0,  0,  0, 0, 0,  2'b00, 2'b00, 2'b00, 4'd5,  0, 1);
        EX      = mk(0,  0,   0,   0, 0, 0,  0,  0, 0, 1,  2'b00, 2'b10, 2'b00, 4'd6,  0, 0);
        AWB     = mk(0,  0,   0,   0, 0, 0,  0,  1, 1, 0,  2'b00, 2'b00, 2'b00, 4'd7,  0, 1);
        BR      = mk(0,  1,   0,   0, 0, 0,  0,  0, 0, 1,  2'b00, 2'b01, 2'b01, 4'd8,  0, 1);
        JMP     = mk(1,  0,   0,   0, 0, 0,  0,  0, 0, 0,  2'b00, 2'b00, 2'b10, 4'd9,  0, 1);
        AX      = mk(0,  0,   0,   0, 0, 0,  0,  0, 0, 1,  2'b10, 2'b00, 2'b00, 4'd10, 0, 0);
        AXWB    = mk(0,  0,   0,   0, 0, 0,  0,  0, 1, 0,  2'b00, 2'b00, 2'b00, 4'd11, 0, 1);
        TRP     = mk(0,  0,   0,   0, 0, 0,  0,  0, 0, 0,  2'b00, 2'b00, 2'b00, 4'd12, 1, 0);

        // Reset held for three cycles, then released with memory not yet ready
        for (int i = 0; i < 3; i++) step(0, 6'h00, 1, ZERO, ZERO, "reset");
        step(1, 6'h00, 0, F_WAIT, F_WAIT, "fetch_wait");

        // lw: 5 cycles, then sw with opcode changed after decode and 2 stall cycles
        step(1, 6'h00, 1, F_RDY, F_RDY, "lw_fetch");
        step(1, 6'h23, 1, DEC, DEC, "lw_decode");
        step(1, 6'h2B, 1, MA, MA, "lw_memadr");
        step(1, 6'h2B, 1, MR_RDY, MR_RDY, "lw_memrd");
        step(1, 6'h2B, 1, MWB, MWB, "lw_memwb");
        step(1, 6'h2B, 1, F_RDY, F_RDY, "sw_fetch");
        step(1, 6'h2B, 1, DEC, DEC, "sw_decode");
        step(1, 6'h23, 1, MA, MA, "sw_memadr");
        step(1, 6'h23, 0, MW_WAIT, MW_WAIT, "sw_memwr_stall1");
        step(1, 6'h23, 0, MW_WAIT, MW_WAIT, "sw_memwr_stall2");
        step(1, 6'h23, 1, MW_RDY, MW_RDY, "sw_memwr_done");

        step(1, 6'h04, 1, F_RDY, F_RDY, "beq_fetch");
        step(1, 6'h04, 1, DEC, DEC, "beq_decode");
        step(1, 6'h04, 1, BR, BR, "beq_branch");

        step(1, 6'h02, 1, F_RDY, F_RDY, "j_fetch");
        step(1, 6'h02, 1, DEC, DEC, "j_decode");
        step(1, 6'h02, 1, JMP, JMP, "j_jump");

        step(1, 6'h00, 1, F_RDY, F_RDY, "r_fetch");
        step(1, 6'h00, 1, DEC, DEC, "r_decode");
        step(1, 6'h00, 1, EX, EX, "r_exec");
        step(1, 6'h00, 1, AWB, AWB, "r_aluwb");

        step(1, 6'h08, 1, F_RDY, F_RDY, "addi_fetch");
        step(1, 6'h08, 1, DEC, DEC, "addi_decode");
        step(1, 6'h08, 1, AX, AX, "addi_exec");
        step(1, 6'h08, 1, AXWB, AXWB, "addi_wb");

        // Illegal opcode: trapping instance parks, the other pulses and refetches
        step(1, 6'h3F, 1, F_RDY, F_RDY, "ill_fetch");
        step(1, 6'h3F, 1, DEC, DEC_ILL, "ill_decode");
        for (int i = 0; i < 12; i++)
            step(1, 6'h3F, 1, TRP, (i % 2 == 0) ? F_RDY : DEC_ILL, "ill_hold");

        // Reset clears the trap; then reset abandons a lw stalled in MEMRD
        step(0, 6'h00, 1, ZERO, ZERO, "trap_reset");
        step(1, 6'h00, 1, F_RDY, F_RDY, "lw2_fetch");
        step(1, 6'h23, 1, DEC, DEC, "lw2_decode");
        step(1, 6'h23, 1, MA, MA, "lw2_memadr");
        step(1, 6'h23, 0, MR_WAIT, MR_WAIT, "lw2_memrd_stall");
        step(1, 6'h23, 0, MR_WAIT, MR_WAIT, "lw2_memrd_stall2");
        step(0, 6'h23, 1, ZERO, ZERO, "memrd_reset");
        step(1, 6'h23, 1, F_RDY, F_RDY, "post_reset_fetch");
        step(1, 6'h23, 1, DEC, DEC, "post_reset_decode");

        @(posedge clk);
        @(posedge clk);
        if (q1.size() != 0 || q0.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d entries left, expected 0", q1.size(), q0.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multi-cycle successor to the single-cycle main decoder.
- Moore/Mealy FSM sequences fetch, decode, execute, memory and writeback over several cycles.
- Shares one memory port, stalled by a mem_ready handshake.
- Adds addi, an illegal-opcode trap and a retire pulse. Sits between the instruction register opcode field and the multicycle datapath muxes and enables.

Parameters:
- OPCODE_W, 6, opcode field width.
- ALU_OP_W, 2, width of alu_op to the ALU control block.
- ENABLE_ADDI, 1, 1 = decode addi (opcode 0x08); 0 = addi is illegal.
- TRAP_ON_ILLEGAL, 1, 1 = illegal opcode parks the FSM in TRAP; 0 = treated as nop.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  OPCODE_W  instr[31:26] from the IR; sampled in DECODE.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero.
- i_or_d  out  1  0 = PC address, 1 = ALU-out address.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  1 = MDR to the register file.
- reg_dst  out  1  1 = rd, 0 = rt.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate.
- alu_op  out  ALU_OP_W  00 = add, 01 = sub, 10 = funct.
- pc_source  out  2  00 = ALU, 01 = ALU-out, 10 = jump target.
- state  out  4  current state code, for debug.
- illegal_op  out  1  illegal opcode flag.
- instr_retired  out  1  one-cycle pulse on instruction completion.

Behaviour:
- Reset: async on rst_n low. State goes to FETCH. While rst_n is low every output is 0; illegal_op is cleared. Reset mid-instruction abandons it with no write.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11, TRAP 12. Codes 13-15 go to FETCH on the next edge with all outputs 0.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write = pc_write = mem_ready (Mealy).
  - Holds until mem_ready, then goes to DECODE.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00.
  - Next state by opcode: 0x23/0x2B -> MEMADR; 0x00 -> EXEC; 0x04 -> BRANCH; 0x02 -> JUMP; 0x08 with ENABLE_ADDI -> ADDIEX.
  - Any other opcode: TRAP if TRAP_ON_ILLEGAL, else FETCH with illegal_op=1 for this cycle only.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEMRD for lw, MEMWR for sw; the opcode class is latched in DECODE.
- MEMRD: mem_read=1, i_or_d=1. Holds until mem_ready, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Then FETCH.
- MEMWR: mem_write=1, i_or_d=1. Holds until mem_ready, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Then ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Then FETCH.
- JUMP: pc_write=1, pc_source=10. Then FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Then ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Then FETCH.
- TRAP: illegal_op=1 and sticky. All enables are 0. Exit only by reset.
- instr_retired: 1 in any cycle whose next state is FETCH from MEMWB, MEMWR (with mem_ready), ALUWB, BRANCH, JUMP or ADDIWB. Not asserted on an illegal-opcode nop.
- Outputs not listed for a state are 0.
- Latencies with mem_ready tied high:
  - lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles.
  - Each mem_ready-low cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Opcode is sampled only in DECODE. Later opcode changes are ignored.

Decomposition:
- Package mips_ctrl_pkg holds:
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI.
  - The 4-bit state enumeration.
  - alu_op codes, alu_src_b encodings and pc_source encodings.
- Sub-module mips_ctrl_opdecode: combinational opcode -> one-hot class (rtype, lw, sw, beq, j, addi, illegal), honouring ENABLE_ADDI.

Test Plan:
- Reset: hold rst_n low 3 cycles -> all outputs 0, state=0. Release -> mem_read=1, and ir_write=1 in the first cycle with mem_ready=1.
- lw (0x23), mem_ready=1 -> states 0,1,2,3,4. reg_write=1 and mem_to_reg=1 in cycle 5, instr_retired=1 in cycle 5.
- sw (0x2B), mem_ready low 2 cycles in MEMWR -> mem_write held 3 cycles, then FETCH. Total 6 cycles; no reg_write at any point.
- beq (0x04) -> BRANCH with pc_write_cond=1, pc_source=01, alu_op=01.
- j (0x02) -> JUMP with pc_write=1, pc_source=10, then FETCH. 3 cycles total.
- Opcode 0x3F with TRAP_ON_ILLEGAL=1 -> state 12, illegal_op stays 1 for 10+ cycles.
- Opcode 0x3F with TRAP_ON_ILLEGAL=0 -> one-cycle illegal_op pulse, then FETCH.
- rst_n low in MEMRD -> immediate state 0, no reg_write.
